// File: rtl/bitlet_plane_accumulator.sv
// ---------------------------------------------------------------------------
// bitlet_plane_accumulator
//
// Consumes the selected-lane stream from the Bitlet check-window stage, one
// weight bit-plane at a time. Each selected lane's activation is fetched,
// negated when that lane's weight is negative, and summed into a per-plane
// partial sum. At each plane end the plane sum is merged into the running
// dot-product total by shift-and-add (MSB plane first). After N_plane planes
// the signed total is presented on result with a one-cycle out_vld pulse.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      1-cycle pulse, begins (or restarts) a dot product
//   act_in     N_total signed activations, lane i at [i*W_act +: W_act]
//   w_sign     per-lane weight sign, 1 = negate
//   sel_vld    check-window selection valid this cycle
//   zero       check window held no 1s; sel is don't-care
//   sel        selected lane index
//   busy       high from the cycle after start until out_vld
//   plane_cnt  number of planes merged so far
//   out_vld    1-cycle pulse, result valid
//   result     signed dot product, held until overwritten by the next run
// ---------------------------------------------------------------------------
module bitlet_plane_accumulator #(
    parameter int N_total = 64,
    parameter int W_act   = 8,
    parameter int N_plane = 8,
    parameter int W_acc   = W_act + $clog2(N_total) + N_plane + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_total*W_act-1:0]      act_in,
    input  logic [N_total-1:0]            w_sign,
    input  logic                          sel_vld,
    input  logic                          zero,
    input  logic [$clog2(N_total)-1:0]    sel,
    output logic                          busy,
    output logic [$clog2(N_plane+1)-1:0]  plane_cnt,
    output logic                          out_vld,
    output logic signed [W_acc-1:0]       result
);

    localparam int CNT_W = $clog2(N_plane + 1);
    localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(N_plane - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, next_state;

    // Pipeline and accumulation registers
    logic signed [W_acc-1:0] term_r;
    logic                    term_v;
    logic                    prev_vld;
    logic                    end_r;
    logic signed [W_acc-1:0] plane_acc;
    logic signed [W_acc-1:0] total;

    // Lane fetch and sign application
    logic [W_act-1:0]        act_sel;
    logic signed [W_acc-1:0] act_ext;
    logic signed [W_acc-1:0] term_next;
    logic                    take_term;
    logic                    merge;
    logic                    last_merge;
    logic signed [W_acc-1:0] total_merged;

    // NOTE: every signal driven here gets a value on every path so no latch is
    // inferred; the leading defaults guarantee that even as cases are added.
    always_comb begin
        act_sel      = act_in[sel*W_act +: W_act];
        act_ext      = {{(W_acc-W_act){act_sel[W_act-1]}}, act_sel};
        term_next    = w_sign[sel] ? -act_ext : act_ext;
        take_term    = sel_vld && !zero && (state == ACCUM);
        merge        = end_r && (state == ACCUM);
        last_merge   = merge && (plane_cnt == LAST_PLANE);
        // A term still in stage 1 at the merge edge belongs to the ending plane.
        total_merged = (total <<< 1) + plane_acc + (term_v ? term_r : '0);
    end

    // Next-state logic; start always wins, which also covers abort/restart.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ACCUM;
        end else begin
            unique case (state)
                IDLE:    next_state = IDLE;
                ACCUM:   if (last_merge) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_r    <= '0;
            term_v    <= 1'b0;
            prev_vld  <= 1'b0;
            end_r     <= 1'b0;
            plane_acc <= '0;
            total     <= '0;
            plane_cnt <= '0;
            out_vld   <= 1'b0;
            result    <= '0;
        end else if (start) begin
            // New run (or abort of the current one): clear everything that
            // belongs to the dot product in flight; result keeps its old value.
            term_r    <= '0;
            term_v    <= 1'b0;
            prev_vld  <= 1'b0;
            end_r     <= 1'b0;
            plane_acc <= '0;
            total     <= '0;
            plane_cnt <= '0;
            out_vld   <= 1'b0;
        end else begin
            // Stage 1: fetch and sign the selected activation.
            term_v <= take_term;
            if (take_term) begin
                term_r <= term_next;
            end

            // Plane end is a falling edge of sel_vld while accumulating.
            if (state == ACCUM) begin
                prev_vld <= sel_vld;
                end_r    <= prev_vld && !sel_vld;
            end else begin
                prev_vld <= 1'b0;
                end_r    <= 1'b0;
            end

            // Stage 2 accumulate, or merge the finished plane into the total.
            if (merge) begin
                total     <= total_merged;
                plane_acc <= '0;
                plane_cnt <= plane_cnt + 1'b1;
            end else if (term_v) begin
                plane_acc <= plane_acc + term_r;
            end

            out_vld <= (state == DONE);
            if (state == DONE) begin
                result <= total;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
